// File: rtl/clock.sv
// 24-hour time-of-day counter: a tick prescaler drives minute steps,
// minute wrap carries into the hour, hour wrap is the day rollover.
module clock #(
    parameter int TICKS_PER_MINUTE = 1,
    parameter int MINUTES_PER_HOUR = 60,
    parameter int HOURS_PER_DAY    = 24
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [5:0] minute,
    output logic [4:0] hour
);
    localparam int TW = (TICKS_PER_MINUTE > 1) ? $clog2(TICKS_PER_MINUTE) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MINUTE - 1);
    localparam logic [5:0]    MIN_LAST  = 6'(MINUTES_PER_HOUR - 1);
    localparam logic [4:0]    HOUR_LAST = 5'(HOURS_PER_DAY - 1);

    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [5:0]    min_nxt;
    logic [4:0]    hour_nxt;
    logic          min_step;
    logic          hour_carry;

    // Wrap tests use >= so a corrupted out-of-range field self-heals to 0
    // on its next step instead of counting up to the width limit.
    always_comb begin
        min_step   = (tick_cnt >= TICK_LAST);
        hour_carry = min_step && (minute >= MIN_LAST);

        tick_nxt = min_step ? '0 : tick_cnt + 1'b1;

        min_nxt = minute;
        if (min_step)
            min_nxt = (minute >= MIN_LAST) ? 6'd0 : minute + 6'd1;

        hour_nxt = hour;
        if (hour_carry)
            hour_nxt = (hour >= HOUR_LAST) ? 5'd0 : hour + 5'd1;
    end

    // rstn is an active-high synchronous clear; it wins over any step.
    always_ff @(posedge clk) begin
        if (rstn) begin
            tick_cnt <= '0;
            minute   <= 6'd0;
            hour     <= 5'd0;
        end else begin
            tick_cnt <= tick_nxt;
            minute   <= min_nxt;
            hour     <= hour_nxt;
        end
    end

endmodule

// File: tb/tb_clock.sv
// Directed bench for clock: one instance at one tick per minute, one with a
// four-tick prescaler. Outputs are sampled on the falling edge.
module tb_clock;
    logic       clk;
    logic       rst1, rst4;
    logic [5:0] m1, m4;
    logic [4:0] h1, h4;

    int n_cmp = 0;
    int n_bad = 0;

    clock #(.TICKS_PER_MINUTE(1)) dut1 (.clk(clk), .rstn(rst1), .minute(m1), .hour(h1));
    clock #(.TICKS_PER_MINUTE(4)) dut4 (.clk(clk), .rstn(rst4), .minute(m4), .hour(h4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each call lets n rising edges pass and returns on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        tick(2);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_2: got %0d:%0d want 0:0", h1, m1);
        end
        tick(10);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %0d:%0d want 0:0", h1, m1);
        end
    endtask

    task automatic test_count;
        rst1 = 1'b0;
        tick(59);
        n_cmp++;
        if (m1 !== 6'd59 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL count_59: got %0d:%0d want 0:59", h1, m1);
        end
        tick(1);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd1) begin
            n_bad++;
            $display("FAIL count_carry: got %0d:%0d want 1:0", h1, m1);
        end
    endtask

    task automatic test_day_rollover;
        rst1 = 1'b1;
        tick(1);
        rst1 = 1'b0;
        tick(1439);
        n_cmp++;
        if (m1 !== 6'd59 || h1 !== 5'd23) begin
            n_bad++;
            $display("FAIL day_2359: got %0d:%0d want 23:59", h1, m1);
        end
        tick(1);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL day_wrap: got %0d:%0d want 0:0", h1, m1);
        end
        tick(720);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd12) begin
            n_bad++;
            $display("FAIL day_noon: got %0d:%0d want 12:0", h1, m1);
        end
        tick(720);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL day_second_wrap: got %0d:%0d want 0:0", h1, m1);
        end
    endtask

    task automatic test_mid_reset;
        rst1 = 1'b1;
        tick(1);
        rst1 = 1'b0;
        tick(75);
        n_cmp++;
        if (m1 !== 6'd15 || h1 !== 5'd1) begin
            n_bad++;
            $display("FAIL mid_115: got %0d:%0d want 1:15", h1, m1);
        end
        rst1 = 1'b1;
        tick(1);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %0d:%0d want 0:0", h1, m1);
        end
        rst1 = 1'b0;
        tick(1);
        n_cmp++;
        if (m1 !== 6'd1 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL mid_release: got %0d:%0d want 0:1", h1, m1);
        end
    endtask

    task automatic test_prescaler;
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
        tick(3);
        n_cmp++;
        if (m4 !== 6'd0 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL pre_3: got %0d:%0d want 0:0", h4, m4);
        end
        tick(1);
        n_cmp++;
        if (m4 !== 6'd1 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL pre_4: got %0d:%0d want 0:1", h4, m4);
        end
        // Partial count of 2 must be discarded by the reset.
        tick(2);
        rst4 = 1'b1;
        tick(1);
        n_cmp++;
        if (m4 !== 6'd0 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL pre_reset: got %0d:%0d want 0:0", h4, m4);
        end
        rst4 = 1'b0;
        tick(3);
        n_cmp++;
        if (m4 !== 6'd0 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL pre_partial: got %0d:%0d want 0:0", h4, m4);
        end
        tick(1);
        n_cmp++;
        if (m4 !== 6'd1 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL pre_full: got %0d:%0d want 0:1", h4, m4);
        end
    endtask

    task automatic test_reset_priority;
        // Single-tick instance: reset lands on the 23:59 -> 0:00 edge.
        rst1 = 1'b1;
        tick(1);
        rst1 = 1'b0;
        tick(1439);
        n_cmp++;
        if (m1 !== 6'd59 || h1 !== 5'd23) begin
            n_bad++;
            $display("FAIL prio1_2359: got %0d:%0d want 23:59", h1, m1);
        end
        rst1 = 1'b1;
        tick(1);
        n_cmp++;
        if (m1 !== 6'd0 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL prio1_reset: got %0d:%0d want 0:0", h1, m1);
        end
        rst1 = 1'b0;
        tick(1);
        n_cmp++;
        if (m1 !== 6'd1 || h1 !== 5'd0) begin
            n_bad++;
            $display("FAIL prio1_next: got %0d:%0d want 0:1", h1, m1);
        end

        // Four-tick instance: 1439*4+3 edges leaves 23:59 with prescaler at 3.
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
        tick(5759);
        n_cmp++;
        if (m4 !== 6'd59 || h4 !== 5'd23) begin
            n_bad++;
            $display("FAIL prio4_2359: got %0d:%0d want 23:59", h4, m4);
        end
        rst4 = 1'b1;
        tick(1);
        n_cmp++;
        if (m4 !== 6'd0 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL prio4_reset: got %0d:%0d want 0:0", h4, m4);
        end
        rst4 = 1'b0;
        tick(3);
        n_cmp++;
        if (m4 !== 6'd0 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL prio4_hold: got %0d:%0d want 0:0", h4, m4);
        end
        tick(1);
        n_cmp++;
        if (m4 !== 6'd1 || h4 !== 5'd0) begin
            n_bad++;
            $display("FAIL prio4_next: got %0d:%0d want 0:1", h4, m4);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        test_reset;
        test_count;
        test_day_rollover;
        test_mid_reset;
        test_prescaler;
        test_reset_priority;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock.md
Name: clock

Overview:
- 24-hour time-of-day counter: minute 0–59 and hour 0–23.
- Advances one minute every TICKS_PER_MINUTE clock cycles.
- Free-running timekeeping leaf block with no handshake.
- Outputs are registered and feed display and compare logic.

Parameters:
- TICKS_PER_MINUTE, 1: number of clk cycles per minute increment; legal range 1 to 2^24-1.
- MINUTES_PER_HOUR, 60: minute wraps from MINUTES_PER_HOUR-1 to 0; must be ≤ 64.
- HOURS_PER_DAY, 24: hour wraps from HOURS_PER_DAY-1 to 0; must be ≤ 32.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstn  input  1  synchronous, active-high reset. rstn=1 at a rising edge resets the block; rstn=0 lets it run.
- minute  output  6  current minute, 0..MINUTES_PER_HOUR-1, registered.
- hour  output  5  current hour, 0..HOURS_PER_DAY-1, registered.

Behaviour:
- One clock domain. No asynchronous paths. Reset is sampled only on the rising edge of clk.
- Reset: at any rising edge with rstn=1, all of the following are cleared to 0:
  - minute
  - hour
  - the internal tick prescaler
- Reset takes priority over any increment on the same edge. A reset applied mid-count discards the partial prescaler count.
- Prescaler:
  - Internal counter tick_cnt, width ceil(log2(TICKS_PER_MINUTE)), minimum 1 bit.
  - On each non-reset edge, if tick_cnt == TICKS_PER_MINUTE-1, tick_cnt returns to 0 and a minute step occurs.
  - Otherwise tick_cnt increments and minute/hour hold.
  - With TICKS_PER_MINUTE=1, every non-reset edge is a minute step.
- Minute step:
  - If minute < MINUTES_PER_HOUR-1, minute increments by 1 and hour holds.
  - If minute == MINUTES_PER_HOUR-1, minute becomes 0 and an hour carry occurs in the same edge.
- Hour carry:
  - If hour < HOURS_PER_DAY-1, hour increments by 1.
  - If hour == HOURS_PER_DAY-1, hour becomes 0. This is the day rollover 23:59 -> 00:00 in one edge.
- Latency:
  - First minute increment occurs TICKS_PER_MINUTE edges after the last reset edge.
  - Outputs change only on rising edges; there is no combinational path from inputs to outputs.
- Out-of-range states (minute ≥ MINUTES_PER_HOUR or hour ≥ HOURS_PER_DAY) are unreachable. If they occur anyway, the next step forces the field to 0 using the wrap rule (≥ comparison, not ==).
- Arithmetic is unsigned. Widths are fixed at 6/5 bits. No overflow beyond the wrap values.
- Before the first reset, output values are don't-care. The bench must apply reset before checking.

Test Plan:
- Reset: hold rstn=1 for 2 edges -> minute=0, hour=0. Keep rstn=1 for 10 more edges -> values stay 0.
- Count (TICKS_PER_MINUTE=1): release reset, run 59 edges -> minute=59, hour=0. Next edge -> minute=0, hour=1.
- Day rollover: run 1439 edges from reset -> hour=23, minute=59. Next edge -> hour=0, minute=0. Run 1440 further edges -> 0:00 again.
- Mid-run reset: after 75 edges (1:15), assert rstn=1 for 1 edge -> 0:00 on that edge. Release -> 0:01 after 1 edge.
- Prescaler (TICKS_PER_MINUTE=4): release reset, 3 edges -> minute=0; 4th edge -> minute=1. Assert reset after 2 further edges, then release -> 4 more edges needed for minute=1.
- Reset priority: assert rstn=1 exactly on the edge where 23:59 would roll over -> result 0:00 and prescaler=0. Next increment occurs TICKS_PER_MINUTE edges after release.
